operand_skewer: RTL and testbench

OPERAND_SKEWER -- requirements
Module: operand_skewer

---
 rtl/systolic_pkg.sv | 18 +
 rtl/skew_lane_mux.sv | 27 ++
 rtl/operand_skewer.sv | 162 ++++++++++++++++
 tb/tb_operand_skewer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared defaults and state encoding for the systolic array front end.
package systolic_pkg;

    localparam int DEF_N      = 4;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } skew_state_e;

    // Step and beat counters must hold 0..2N-1 without wrapping.
    function automatic int cnt_width(input int n);
        return $clog2(2 * n);
    endfunction

endpackage

// File: rtl/skew_lane_mux.sv
// Picks the element a single edge lane presents at step t, zero outside the
// lane's diagonal window.
module skew_lane_mux
    import systolic_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = 3,
    parameter int LANE   = 0
) (
    input  logic [N*DATA_W-1:0] elems,
    input  logic [CNT_W-1:0]    t,
    input  logic                en,
    output logic [DATA_W-1:0]   elem
);

    // Lane LANE shows element t-LANE; any t outside [LANE, LANE+N) yields 0.
    always_comb begin
        elem = '0;
        for (int k = 0; k < N; k++) begin
            if (en && (int'(t) == k + LANE)) begin
                elem = elems[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/operand_skewer.sv
// Buffers an A/B operand pair and feeds it diagonally skewed into the west and
// north edges of an N x N systolic array.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_LOAD   | accept N beats (row r of A, column r of B)
//   ST_STREAM | drive steps t = 0..2N-2 onto the array edges
//   ST_DRAIN  | wait DRAIN_CYC cycles for the PE pipeline, then pulse done
module operand_skewer
    import systolic_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DRAIN_CYC = 2 * N
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*DATA_W-1:0] in_a_row,
    input  logic [N*DATA_W-1:0] in_b_col,
    output logic [N*DATA_W-1:0] out_west,
    output logic [N*DATA_W-1:0] out_north,
    output logic                out_valid,
    output logic                done
);

    localparam int CNT_W = cnt_width(N);
    localparam int DRN_W = ($clog2(DRAIN_CYC) > CNT_W) ? $clog2(DRAIN_CYC) : CNT_W;

    skew_state_e         state_q, state_d;
    logic [CNT_W-1:0]    beat_q, beat_d;
    logic [CNT_W-1:0]    t_q, t_d;
    logic [DRN_W-1:0]    drn_q, drn_d;
    logic                in_ready_d, out_valid_d, done_d;
    logic                load_we;
    logic [N*DATA_W-1:0] west_d, north_d;

    logic [N*DATA_W-1:0] a_buf  [N];
    logic [N*DATA_W-1:0] b_buf  [N];
    logic [N*DATA_W-1:0] a_view [N];
    logic [N*DATA_W-1:0] b_view [N];

    always_ff @(posedge clk) begin
        for (int r = 0; r < N; r++) begin
            if (load_we && (beat_q == CNT_W'(r))) begin
                a_buf[r] <= in_a_row;
                b_buf[r] <= in_b_col;
            end
        end
    end

    // Write-through view so the edge accepting the last beat can already
    // register step 0 without depending on N > 1.
    always_comb begin
        a_view = a_buf;
        b_view = b_buf;
        for (int r = 0; r < N; r++) begin
            if (load_we && (beat_q == CNT_W'(r))) begin
                a_view[r] = in_a_row;
                b_view[r] = in_b_col;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        t_d         = t_q;
        drn_d       = drn_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        load_we     = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (in_valid && in_ready) begin
                    load_we = 1'b1;
                    if (beat_q == CNT_W'(N - 1)) begin
                        beat_d      = '0;
                        t_d         = '0;
                        out_valid_d = 1'b1;
                        state_d     = ST_STREAM;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                if (t_q == CNT_W'(2 * N - 2)) begin
                    t_d     = '0;
                    drn_d   = DRN_W'(DRAIN_CYC - 1);
                    state_d = ST_DRAIN;
                end else begin
                    t_d         = t_q + 1'b1;
                    out_valid_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drn_q == '0) begin
                    done_d  = 1'b1;
                    beat_d  = '0;
                    state_d = ST_LOAD;
                end else begin
                    drn_d = drn_q - 1'b1;
                end
            end
            default: state_d = ST_LOAD;
        endcase
        // The done cycle keeps in_ready low so no beat can coincide with it.
        in_ready_d = (state_d == ST_LOAD) && !done_d;
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_lane_mux #(
            .N      (N),
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W),
            .LANE   (i)
        ) u_west (
            .elems (a_view[i]),
            .t     (t_d),
            .en    (out_valid_d),
            .elem  (west_d[i*DATA_W +: DATA_W])
        );
        skew_lane_mux #(
            .N      (N),
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W),
            .LANE   (i)
        ) u_north (
            .elems (b_view[i]),
            .t     (t_d),
            .en    (out_valid_d),
            .elem  (north_d[i*DATA_W +: DATA_W])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_LOAD;
            beat_q    <= '0;
            t_q       <= '0;
            drn_q     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            out_west  <= '0;
            out_north <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            t_q       <= t_d;
            drn_q     <= drn_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            done      <= done_d;
            out_west  <= west_d;
            out_north <= north_d;
        end
    end

endmodule

// File: tb/tb_operand_skewer.sv
// Scoreboard bench for operand_skewer: loads operand pairs and checks the
// skewed edge streams, stream length, done timing and reset behaviour.
module tb_operand_skewer;

    localparam int N      = 4;
    localparam int DATA_W = 8;
    localparam int W      = N * DATA_W;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a_row;
    logic [W-1:0] in_b_col;
    logic [W-1:0] out_west;
    logic [W-1:0] out_north;
    logic         out_valid;
    logic         done;
    logic         rst_at_edge;

    typedef struct {
        logic [W-1:0] w;
        logic [W-1:0] n;
    } vec_t;

    vec_t exp_q[$];
    int   ma[N][N];
    int   mb[N][N];
    int   vectors     = 0;
    int   miscompares = 0;

    operand_skewer #(.N(N), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a_row  (in_a_row),
        .in_b_col  (in_b_col),
        .out_west  (out_west),
        .out_north (out_north),
        .out_valid (out_valid),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) rst_at_edge <= rst;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pack_a(input int r);
        logic [W-1:0] v;
        for (int k = 0; k < N; k++) v[k*DATA_W +: DATA_W] = DATA_W'(ma[r][k]);
        return v;
    endfunction

    function automatic logic [W-1:0] pack_b(input int r);
        logic [W-1:0] v;
        for (int k = 0; k < N; k++) v[k*DATA_W +: DATA_W] = DATA_W'(mb[k][r]);
        return v;
    endfunction

    // Reference: step t shows A[i][t-i] on west lane i and B[t-j][j] on north lane j.
    task automatic push_expected();
        vec_t e;
        for (int t = 0; t < 2 * N - 1; t++) begin
            e.w = '0;
            e.n = '0;
            for (int i = 0; i < N; i++) begin
                if (t - i >= 0 && t - i < N) begin
                    e.w[i*DATA_W +: DATA_W] = DATA_W'(ma[i][t - i]);
                    e.n[i*DATA_W +: DATA_W] = DATA_W'(mb[t - i][i]);
                end
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic rand_mats();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = int'($urandom_range(0, 255));
                mb[i][j] = int'($urandom_range(0, 255));
            end
    endtask

    // Returns right after the edge accepting the last beat (step 0 on outputs).
    task automatic load_pair(input bit toggle, input bit hold);
        bit ok;
        int waited;
        for (int r = 0; r < N; r++) begin
            in_a_row = pack_a(r);
            in_b_col = pack_b(r);
            in_valid = 1'b1;
            waited   = 0;
            ok       = 1'b0;
            while (!ok) begin
                @(negedge clk);
                ok = in_ready;
                @(posedge clk);
                #1;
                if (!ok && ++waited > 200) begin
                    chk("beat_accept_timeout", 64'(waited), 64'd0);
                    in_valid = 1'b0;
                    return;
                end
            end
            if (r == N - 1) push_expected();
            if (toggle && r < N - 1) begin
                in_valid = 1'b0;
                in_a_row = W'($urandom);
                in_b_col = W'($urandom);
                @(posedge clk);
                #1;
            end
        end
        if (hold) begin
            fork
                begin
                    for (int c = 0; c < 2 * N + 2; c++) begin
                        in_a_row = W'($urandom);
                        in_b_col = W'($urandom);
                        @(posedge clk);
                        #1;
                    end
                    in_valid = 1'b0;
                end
            join_none
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int c = 0;
        while (1) begin
            @(negedge clk);
            if (done) break;
            if (++c > 8 * N + 40) begin
                chk("done_timeout", 64'(c), 64'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        vec_t e;
        int   run        = 0;
        int   since_fall = -1;
        bit   prev_v     = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_at_edge !== 1'b1) begin
                chk("reset_ctrl", {61'd0, out_valid, done, in_ready}, 64'd0);
                chk("reset_west", 64'(out_west), 64'd0);
                chk("reset_north", 64'(out_north), 64'd0);
                run        = 0;
                since_fall = -1;
                prev_v     = 1'b0;
            end else begin
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("west", 64'(out_west), 64'(e.w));
                        chk("north", 64'(out_north), 64'(e.n));
                    end
                    chk("ready_while_valid", 64'(in_ready), 64'd0);
                    run++;
                    since_fall = -1;
                end else begin
                    chk("west_idle", 64'(out_west), 64'd0);
                    chk("north_idle", 64'(out_north), 64'd0);
                    if (prev_v) begin
                        chk("stream_len", 64'(run), 64'(2 * N - 1));
                        run        = 0;
                        since_fall = 0;
                    end else if (since_fall >= 0) begin
                        since_fall++;
                    end
                end
                chk("done", 64'(done), 64'(since_fall == 2 * N));
                if (done) begin
                    chk("ready_at_done", 64'(in_ready), 64'd0);
                    since_fall = -1;
                end
                prev_v = out_valid;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_a_row = '0;
        in_b_col = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Directed A = 1..16, random B; west edge at t=3 is {13,10,7,4}.
        rand_mats();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) ma[i][j] = 4 * i + j + 1;
        load_pair(1'b0, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("west_t3", 64'(out_west), 64'h0D0A0704);
        wait_done();

        // Identity B.
        rand_mats();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) mb[i][j] = (i == j) ? 1 : 0;
        load_pair(1'b0, 1'b0);
        wait_done();

        // in_valid held high through the stream with changing data.
        rand_mats();
        load_pair(1'b0, 1'b1);
        wait_done();

        // in_valid toggling during LOAD.
        rand_mats();
        load_pair(1'b1, 1'b0);
        wait_done();

        // Reset while step 2 is displayed, then a clean reload.
        rand_mats();
        load_pair(1'b0, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        rand_mats();
        load_pair(1'b0, 1'b0);
        wait_done();

        // Back-to-back pairs: the second load waits for the done pulse.
        rand_mats();
        load_pair(1'b0, 1'b0);
        rand_mats();
        load_pair(1'b1, 1'b0);
        wait_done();

        // A few more random pairs.
        for (int p = 0; p < 4; p++) begin
            rand_mats();
            load_pair(p[0], p[1]);
            wait_done();
        end

        repeat (4) @(posedge clk);
        #1;
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
